// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the data-memory bridge: MMIO register map, TCTRL
// bit positions and byte-lane helpers used by the top level and the timer.
package dmem_bridge_pkg;

    // Register select taken from addr[3:1]; byte offsets are twice these values
    typedef enum logic [2:0] {
        REG_TCNT    = 3'd0,
        REG_TCTRL   = 3'd1,
        REG_TRELOAD = 3'd2,
        REG_GPOUT   = 3'd3,
        REG_GPIN    = 3'd4,
        REG_RSV5    = 3'd5,
        REG_RSV6    = 3'd6,
        REG_RSV7    = 3'd7
    } mmio_reg_e;

    localparam logic [3:0] OFF_TCNT    = 4'h0;
    localparam logic [3:0] OFF_TCTRL   = 4'h2;
    localparam logic [3:0] OFF_TRELOAD = 4'h4;
    localparam logic [3:0] OFF_GPOUT   = 4'h6;
    localparam logic [3:0] OFF_GPIN    = 4'h8;

    localparam int unsigned TCTRL_EN   = 0;
    localparam int unsigned TCTRL_AUTO = 1;
    localparam int unsigned TCTRL_PEND = 2;
    localparam int unsigned TCTRL_IE   = 3;

    function automatic logic [1:0] lane_en(input logic byt, input logic a0);
        logic [1:0] be;
        if (!byt) begin
            be = 2'b11;
        end else if (a0) begin
            be = 2'b10;
        end else begin
            be = 2'b01;
        end
        return be;
    endfunction

    function automatic logic [15:0] lane_merge(input logic [15:0] old_val,
                                               input logic [15:0] wdata,
                                               input logic [1:0]  be);
        logic [15:0] res;
        res = old_val;
        if (be[0]) begin
            res[7:0] = wdata[7:0];
        end
        if (be[1]) begin
            res[15:8] = wdata[15:8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_timer.sv
// Millisecond down-counter timer: prescaler, TCNT/TRELOAD/TCTRL registers,
// pending flag and level interrupt output.
module dmem_timer
    import dmem_bridge_pkg::*;
#(
    parameter int unsigned CLOCK_HZ = 27000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wen,
    input  mmio_reg_e   i_reg,
    input  logic [1:0]  i_be,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_rdata,
    output logic        o_irq
);

    localparam int unsigned PRESC_DIV = (CLOCK_HZ / 1000 > 0) ? CLOCK_HZ / 1000 : 1;
    localparam int unsigned PRESC_W   = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESC_DIV - 1);

    logic [PRESC_W-1:0] r_presc;
    logic [15:0]        r_tcnt;
    logic [15:0]        r_treload;
    logic               r_en;
    logic               r_auto;
    logic               r_pend;
    logic               r_ie;

    logic               w_tick;
    logic               w_expire;
    logic               w_wr_tcnt;
    logic               w_wr_tctrl;
    logic               w_wr_treload;
    logic               w_w1c;
    logic               w_en_nxt;
    logic [PRESC_W-1:0] w_presc_nxt;
    logic [15:0]        w_tcnt_nxt;

    assign w_tick       = r_en && (r_presc == PRESC_MAX);
    assign w_expire     = w_tick && (r_tcnt == 16'd1);
    assign w_wr_tcnt    = i_wen && (i_reg == REG_TCNT);
    assign w_wr_tctrl   = i_wen && (i_reg == REG_TCTRL) && i_be[0];
    assign w_wr_treload = i_wen && (i_reg == REG_TRELOAD);
    assign w_w1c        = w_wr_tctrl && i_wdata[TCTRL_PEND];
    assign w_en_nxt     = w_wr_tctrl ? i_wdata[TCTRL_EN] : r_en;

    // Disabling EN clears the prescaler in the same cycle as the TCTRL write
    always_comb begin
        w_presc_nxt = r_presc + 1'b1;
        if (!r_en || !w_en_nxt || w_tick) begin
            w_presc_nxt = '0;
        end
    end

    always_comb begin
        w_tcnt_nxt = r_tcnt;
        if (w_wr_tcnt) begin
            w_tcnt_nxt = lane_merge(r_tcnt, i_wdata, i_be);
        end else if (w_tick) begin
            if (r_tcnt > 16'd1) begin
                w_tcnt_nxt = r_tcnt - 16'd1;
            end else if (r_tcnt == 16'd1) begin
                w_tcnt_nxt = r_auto ? r_treload : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc   <= '0;
            r_tcnt    <= '0;
            r_treload <= '0;
            r_en      <= 1'b0;
            r_auto    <= 1'b0;
            r_pend    <= 1'b0;
            r_ie      <= 1'b0;
        end else begin
            r_presc <= w_presc_nxt;
            r_tcnt  <= w_tcnt_nxt;
            if (w_wr_treload) begin
                r_treload <= lane_merge(r_treload, i_wdata, i_be);
            end
            if (w_wr_tctrl) begin
                r_en   <= i_wdata[TCTRL_EN];
                r_auto <= i_wdata[TCTRL_AUTO];
                r_ie   <= i_wdata[TCTRL_IE];
            end
            // A set on expiry overrides a same-cycle write-1-to-clear
            r_pend <= w_expire | (r_pend & ~w_w1c);
        end
    end

    always_comb begin
        o_rdata = '0;
        case (i_reg)
            REG_TCNT:    o_rdata = r_tcnt;
            REG_TCTRL:   o_rdata = {12'h000, r_ie, r_pend, r_auto, r_en};
            REG_TRELOAD: o_rdata = r_treload;
            default:     o_rdata = '0;
        endcase
    end

    assign o_irq = r_pend & r_ie;

endmodule

// File: rtl/dmem_bridge.sv
// CPU data-memory bridge: decodes accesses to on-chip RAM or the MMIO window
// (timer + GPIO) and returns registered read data one cycle after ren.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned CLOCK_HZ   = 27000000,
    parameter int unsigned RAM_WORDS  = 2048,
    parameter logic [ADDR_WIDTH-1:0] MMIO_BASE = ADDR_WIDTH'(12'hF00)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] dmem_addr,
    input  logic                  dmem_ren,
    input  logic                  dmem_wen,
    input  logic                  dmem_byt,
    input  logic [15:0]           dmem_wdata,
    output logic [15:0]           dmem_rdata,
    output logic                  irq,
    input  logic [7:0]            gpio_in,
    output logic [7:0]            gpio_out
);

    localparam int unsigned RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    logic [15:0] r_ram [RAM_WORDS];
    logic [15:0] r_rdata;
    logic [7:0]  r_gpout;
    logic [7:0]  r_gpin_meta;
    logic [7:0]  r_gpin_sync;

    logic                  w_mmio;
    logic [ADDR_WIDTH-2:0] w_word;
    logic                  w_ram_hit;
    logic [RAM_AW-1:0]     w_ram_idx;
    logic [1:0]            w_be;
    mmio_reg_e             w_reg;
    logic [15:0]           w_ram_rd;
    logic [15:0]           w_tmr_rdata;
    logic [15:0]           w_mmio_rd;
    logic                  w_tmr_irq;

    assign w_mmio    = (dmem_addr[ADDR_WIDTH-1:4] == MMIO_BASE[ADDR_WIDTH-1:4]);
    assign w_word    = dmem_addr[ADDR_WIDTH-1:1];
    // MMIO decode takes priority over any RAM word it overlays
    assign w_ram_hit = !w_mmio && (32'(w_word) < RAM_WORDS);
    assign w_ram_idx = w_word[RAM_AW-1:0];
    assign w_be      = lane_en(dmem_byt, dmem_addr[0]);
    assign w_reg     = mmio_reg_e'(dmem_addr[3:1]);

    always_ff @(posedge clk) begin
        if (dmem_wen && w_ram_hit) begin
            if (w_be[0]) begin
                r_ram[w_ram_idx][7:0] <= dmem_wdata[7:0];
            end
            if (w_be[1]) begin
                r_ram[w_ram_idx][15:8] <= dmem_wdata[15:8];
            end
        end
    end

    assign w_ram_rd = w_ram_hit ? r_ram[w_ram_idx] : '0;

    dmem_timer #(
        .CLOCK_HZ(CLOCK_HZ)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_wen   (dmem_wen && w_mmio),
        .i_reg   (w_reg),
        .i_be    (w_be),
        .i_wdata (dmem_wdata),
        .o_rdata (w_tmr_rdata),
        .o_irq   (w_tmr_irq)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gpout     <= '0;
            r_gpin_meta <= '0;
            r_gpin_sync <= '0;
        end else begin
            r_gpin_meta <= gpio_in;
            r_gpin_sync <= r_gpin_meta;
            if (dmem_wen && w_mmio && (w_reg == REG_GPOUT) && w_be[0]) begin
                r_gpout <= dmem_wdata[7:0];
            end
        end
    end

    always_comb begin
        w_mmio_rd = '0;
        case (w_reg)
            REG_TCNT, REG_TCTRL, REG_TRELOAD: w_mmio_rd = w_tmr_rdata;
            REG_GPOUT: w_mmio_rd = {8'h00, r_gpout};
            REG_GPIN:  w_mmio_rd = {8'h00, r_gpin_sync};
            default:   w_mmio_rd = '0;
        endcase
    end

    // Captured from pre-write state, so a same-cycle write reads first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (dmem_ren) begin
            r_rdata <= w_mmio ? w_mmio_rd : w_ram_rd;
        end
    end

    assign dmem_rdata = r_rdata;
    assign irq        = w_tmr_irq;
    assign gpio_out   = r_gpout;

endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: a behavioural model predicts read data,
// irq and gpio_out per cycle; a negedge monitor pops and compares.
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] dmem_addr;
    logic        dmem_ren;
    logic        dmem_wen;
    logic        dmem_byt;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        irq;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;

    always #5 clk = ~clk;

    dmem_bridge #(
        .ADDR_WIDTH(16),
        .CLOCK_HZ  (1000),
        .RAM_WORDS (2048),
        .MMIO_BASE (16'h0F00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dmem_addr  (dmem_addr),
        .dmem_ren   (dmem_ren),
        .dmem_wen   (dmem_wen),
        .dmem_byt   (dmem_byt),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .irq        (irq),
        .gpio_in    (gpio_in),
        .gpio_out   (gpio_out)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } rd_t;
    typedef struct {
        logic       irq;
        logic [7:0] gpo;
    } st_t;

    rd_t rd_q[$];
    st_t st_q[$];

    logic [15:0] m_ram [int];
    int          wq[$];
    logic [15:0] m_tcnt, m_trel;
    logic        m_en, m_auto, m_pend, m_ie;
    logic [7:0]  m_gpout, m_s1, m_s2;

    function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] w,
                                          input logic [1:0] be);
        logic [15:0] r;
        r = o;
        if (be[0]) r[7:0] = w[7:0];
        if (be[1]) r[15:8] = w[15:8];
        return r;
    endfunction

    task automatic model_reset();
        m_tcnt = 0; m_trel = 0; m_en = 0; m_auto = 0; m_pend = 0; m_ie = 0;
        m_gpout = 0; m_s1 = 0; m_s2 = 0;
    endtask

    task automatic model_step(input logic ren, input logic wen, input logic byt,
                              input logic [15:0] addr, input logic [15:0] wd);
        logic [1:0]  be;
        logic        mmio, tick, expire, wr_c;
        int          off, widx;
        logic [15:0] rv, nt;
        rd_t         r;
        st_t         s;
        be   = !byt ? 2'b11 : (addr[0] ? 2'b10 : 2'b01);
        mmio = (addr[15:4] == 12'h0F0);
        off  = int'(addr[3:0]) & 14;
        widx = int'(addr[15:1]);
        if (ren) begin
            rv = 16'h0000;
            if (mmio) begin
                case (off)
                    0: rv = m_tcnt;
                    2: rv = {12'h000, m_ie, m_pend, m_auto, m_en};
                    4: rv = m_trel;
                    6: rv = {8'h00, m_gpout};
                    8: rv = {8'h00, m_s2};
                    default: rv = 16'h0000;
                endcase
            end else if (widx < 2048) begin
                rv = m_ram[widx];
            end
            r.addr = addr;
            r.data = rv;
            rd_q.push_back(r);
        end
        // timer: one tick per enabled cycle at 1 kHz clock
        tick   = m_en;
        expire = tick && (m_tcnt == 16'd1);
        nt = m_tcnt;
        if (wen && mmio && off == 0) nt = merge(m_tcnt, wd, be);
        else if (tick && m_tcnt > 1) nt = m_tcnt - 1;
        else if (expire) nt = m_auto ? m_trel : 16'h0000;
        wr_c = wen && mmio && off == 2 && be[0];
        m_pend = expire || (m_pend && !(wr_c && wd[2]));
        m_tcnt = nt;
        if (wr_c) begin
            m_en = wd[0]; m_auto = wd[1]; m_ie = wd[3];
        end
        if (wen && mmio && off == 4) m_trel = merge(m_trel, wd, be);
        if (wen && mmio && off == 6 && be[0]) m_gpout = wd[7:0];
        if (wen && !mmio && widx < 2048) begin
            if (!m_ram.exists(widx)) begin
                m_ram[widx] = wd;
                wq.push_back(widx);
            end else begin
                m_ram[widx] = merge(m_ram[widx], wd, be);
            end
        end
        m_s2 = m_s1;
        m_s1 = gpio_in;
        s.irq = m_pend && m_ie;
        s.gpo = m_gpout;
        st_q.push_back(s);
    endtask

    // ---------------- monitor ----------------
    logic step_active = 1'b0;
    logic ren_d, chk_d;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ren_d <= 1'b0;
            chk_d <= 1'b0;
        end else begin
            ren_d <= dmem_ren;
            chk_d <= step_active;
        end
    end

    always @(negedge clk) begin
        st_t s;
        rd_t r;
        if (chk_d) begin
            if (st_q.size() == 0) begin
                chk("state_queue_underflow", 16'd0, 16'd1);
            end else begin
                s = st_q.pop_front();
                chk("irq", {15'd0, irq}, {15'd0, s.irq});
                chk("gpio_out", {8'h00, gpio_out}, {8'h00, s.gpo});
            end
        end
        if (ren_d) begin
            if (rd_q.size() == 0) begin
                chk("read_queue_underflow", 16'd0, 16'd1);
            end else begin
                r = rd_q.pop_front();
                chk($sformatf("rdata[%h]", r.addr), dmem_rdata, r.data);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic ren, input logic wen, input logic byt,
                        input logic [15:0] addr, input logic [15:0] wd);
        dmem_ren = ren; dmem_wen = wen; dmem_byt = byt;
        dmem_addr = addr; dmem_wdata = wd;
        step_active = 1'b1;
        model_step(ren, wen, byt, addr, wd);
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic byt);
        step(1'b0, 1'b1, byt, a, d);
    endtask
    task automatic rd(input logic [15:0] a);
        step(1'b1, 1'b0, 1'b0, a, 16'h0000);
    endtask
    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    initial begin
        rst = 1'b1;
        dmem_addr = 0; dmem_ren = 0; dmem_wen = 0; dmem_byt = 0; dmem_wdata = 0;
        gpio_in = 8'h00;
        model_reset();
        #1;
        chk("reset_rdata", dmem_rdata, 16'h0000);
        chk("reset_irq", {15'd0, irq}, 16'h0000);
        chk("reset_gpio_out", {8'h00, gpio_out}, 16'h0000);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // RAM word/byte lanes and out-of-range read
        wr(16'h0102, 16'hDEAD, 1'b0);
        wr(16'h0103, 16'h1200, 1'b1);
        rd(16'h0102);
        rd(16'h3000);
        wr(16'h3000, 16'hBEEF, 1'b0);
        rd(16'h3000);
        step(1'b1, 1'b1, 1'b0, 16'h0102, 16'h5555);
        rd(16'h0102);
        wr(16'h0102, 16'h12AD, 1'b0);

        // one-shot timer
        wr(16'h0F00, 16'h0003, 1'b0);
        wr(16'h0F02, 16'h0009, 1'b0);
        for (int i = 0; i < 5; i++) rd(16'h0F00);
        rd(16'h0F02);
        wr(16'h0F02, 16'h0004, 1'b0);
        rd(16'h0F02);

        // auto-reload
        wr(16'h0F04, 16'h0002, 1'b0);
        wr(16'h0F00, 16'h0001, 1'b0);
        wr(16'h0F02, 16'h000B, 1'b0);
        rd(16'h0F00);
        wr(16'h0F02, 16'h000F, 1'b0);
        for (int i = 0; i < 4; i++) rd(16'h0F00);

        // collisions: W1C on expiry cycle, TCNT write on tick cycle
        wr(16'h0F00, 16'h0002, 1'b0);
        idle();
        wr(16'h0F02, 16'h000F, 1'b0);
        rd(16'h0F02);
        wr(16'h0F00, 16'h0050, 1'b0);
        rd(16'h0F00);
        wr(16'h0F01, 16'h1200, 1'b1);
        rd(16'h0F00);
        wr(16'h0F02, 16'h0004, 1'b0);

        // GPIO
        wr(16'h0F06, 16'h00A5, 1'b1);
        wr(16'h0F07, 16'h5A00, 1'b1);
        gpio_in = 8'h3C;
        for (int i = 0; i < 4; i++) rd(16'h0F08);
        wr(16'h0F08, 16'hFFFF, 1'b0);
        rd(16'h0F06);
        rd(16'h0F0A);

        // async reset with irq pending, TCNT=5, gpio_out=A5
        wr(16'h0F00, 16'h0001, 1'b0);
        wr(16'h0F02, 16'h0009, 1'b0);
        idle();
        wr(16'h0F02, 16'h0008, 1'b0);
        wr(16'h0F00, 16'h0005, 1'b0);
        rd(16'h0F00);
        @(negedge clk); #1;
        chk("pre_reset_irq", {15'd0, irq}, 16'h0001);
        chk("pre_reset_rdata", dmem_rdata, 16'h0005);
        rst = 1'b1;
        #1;
        chk("async_reset_irq", {15'd0, irq}, 16'h0000);
        chk("async_reset_gpio_out", {8'h00, gpio_out}, 16'h0000);
        chk("async_reset_rdata", dmem_rdata, 16'h0000);
        model_reset();
        step_active = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        rd(16'h0F00);
        rd(16'h0F02);
        rd(16'h0F06);
        rd(16'h0102);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            int unsigned sel;
            int          idx;
            logic [15:0] a;
            sel = $urandom_range(0, 9);
            if (sel <= 2) begin
                idx = int'($urandom_range(0, 63));
                a = 16'(idx * 2 + int'($urandom_range(0, 1)));
                step(m_ram.exists(idx) && ($urandom_range(0, 3) == 0), 1'b1, 1'b0,
                     a, 16'($urandom));
            end else if (sel == 3 && wq.size() > 0) begin
                idx = wq[$urandom_range(0, wq.size() - 1)];
                a = 16'(idx * 2 + int'($urandom_range(0, 1)));
                step($urandom_range(0, 1) == 1, 1'b1, 1'b1, a, 16'($urandom));
            end else if (sel <= 5) begin
                if (wq.size() > 0 && $urandom_range(0, 3) != 0) begin
                    idx = wq[$urandom_range(0, wq.size() - 1)];
                    a = 16'(idx * 2 + int'($urandom_range(0, 1)));
                end else begin
                    a = 16'h1000 + 16'($urandom_range(0, 16'h0FFF));
                end
                step(1'b1, $urandom_range(0, 4) == 0 && a >= 16'h1000,
                     $urandom_range(0, 1) == 1, a, 16'($urandom));
            end else if (sel <= 7) begin
                a = 16'h0F00 + 16'($urandom_range(0, 15));
                step(1'b1, 1'b0, $urandom_range(0, 1) == 1, a, 16'h0000);
            end else if (sel == 8) begin
                a = 16'h0F00 + 16'($urandom_range(0, 15));
                step($urandom_range(0, 1) == 1, 1'b1, $urandom_range(0, 1) == 1,
                     a, 16'($urandom_range(0, 16'h00FF)) | (16'($urandom) & 16'hFF00));
            end else begin
                if ($urandom_range(0, 1) == 1) gpio_in = 8'($urandom);
                idle();
            end
        end

        idle();
        @(negedge clk); #1;
        chk("read_queue_drained", 16'(rd_q.size()), 16'd0);
        chk("state_queue_drained", 16'(st_q.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
